// File: rtl/pwm_deadtime_gen.sv
// Multi-channel edge-aligned PWM with double-buffered period/duty/dead time
// and complementary high/low gate drives separated by a programmable gap.

module pwm_dt_lane #(
  parameter int DT_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CE,
  input  logic                en,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                h,
  output logic                l
);
  logic                raw_q;
  logic                en_q;
  logic [DT_WIDTH-1:0] dt;
  logic                edge_seen;

  // Re-enabling is handled like a raw edge so the gap is honoured on resume.
  assign edge_seen = (raw != raw_q) || !en_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      raw_q <= 1'b0;
      en_q  <= 1'b0;
      dt    <= '0;
      h     <= 1'b0;
      l     <= 1'b0;
    end else if (!en) begin
      h    <= 1'b0;
      l    <= 1'b0;
      dt   <= '0;
      en_q <= 1'b0;
      if (CE) raw_q <= raw;
    end else if (CE) begin
      raw_q <= raw;
      en_q  <= 1'b1;
      if (edge_seen) begin
        if (deadtime == '0) begin
          h  <= raw;
          l  <= ~raw;
          dt <= '0;
        end else begin
          h  <= 1'b0;
          l  <= 1'b0;
          dt <= deadtime;
        end
      end else if (dt != '0) begin
        // The edge cycle is the first low cycle, so drive on the last tick.
        dt <= dt - 1'b1;
        h  <= (dt == DT_WIDTH'(1)) &  raw_q;
        l  <= (dt == DT_WIDTH'(1)) & ~raw_q;
      end else begin
        h <= raw_q;
        l <= ~raw_q;
      end
    end
  end
endmodule

module pwm_deadtime_gen #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int DT_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CE,
  input  logic                      EN,
  input  logic                      LOAD,
  input  logic [WIDTH-1:0]          PERIOD,
  input  logic [CHANNELS*WIDTH-1:0] DUTY,
  input  logic [DT_WIDTH-1:0]       DEADTIME,
  output logic [CHANNELS-1:0]       PWM_H,
  output logic [CHANNELS-1:0]       PWM_L,
  output logic                      SYNC
);
  logic [WIDTH-1:0]                 cnt;
  logic [WIDTH-1:0]                 act_period, sh_period;
  logic [CHANNELS-1:0][WIDTH-1:0]   act_duty, sh_duty;
  logic [DT_WIDTH-1:0]              act_dt, sh_dt;
  logic                             pending;
  logic                             running;
  logic                             wrap;
  logic                             apply;
  logic [CHANNELS-1:0]              raw;

  assign wrap  = (cnt == act_period);
  assign apply = CE && wrap && pending;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      act_period <= '0;
      sh_period  <= '0;
      act_duty   <= '0;
      sh_duty    <= '0;
      act_dt     <= '0;
      sh_dt      <= '0;
      pending    <= 1'b0;
      running    <= 1'b0;
      SYNC       <= 1'b0;
    end else begin
      // A LOAD coinciding with an apply stays pending for the next wrap.
      if (LOAD) begin
        sh_period <= PERIOD;
        sh_duty   <= DUTY;
        sh_dt     <= DEADTIME;
        pending   <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
      if (CE) begin
        cnt  <= wrap ? '0 : cnt + 1'b1;
        SYNC <= (cnt == '0);
      end else begin
        SYNC <= 1'b0;
      end
      // Outputs stay parked low until a configuration has been applied.
      if (apply) begin
        act_period <= sh_period;
        act_duty   <= sh_duty;
        act_dt     <= sh_dt;
        running    <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign raw[i] = (cnt < act_duty[i]);
    pwm_dt_lane #(.DT_WIDTH(DT_WIDTH)) u_lane (
      .CLK      (CLK),
      .RST      (RST),
      .CE       (CE),
      .en       (EN && running),
      .raw      (raw[i]),
      .deadtime (act_dt),
      .h        (PWM_H[i]),
      .l        (PWM_L[i])
    );
  end
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed plus random stimulus against a cycle-level reference model that
// describes dead time as "age since last edge" rather than a countdown.

module tb_pwm_deadtime_gen;
  localparam int W = 8;
  localparam int C = 3;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         CE = 1'b0;
  logic         EN = 1'b0;
  logic         LOAD = 1'b0;
  logic [W-1:0] PERIOD = '0;
  logic [C*W-1:0] DUTY = '0;
  logic [D-1:0] DEADTIME = '0;
  logic [C-1:0] PWM_H, PWM_L;
  logic         SYNC;

  pwm_deadtime_gen #(.WIDTH(W), .CHANNELS(C), .DT_WIDTH(D)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .EN(EN), .LOAD(LOAD),
    .PERIOD(PERIOD), .DUTY(DUTY), .DEADTIME(DEADTIME),
    .PWM_H(PWM_H), .PWM_L(PWM_L), .SYNC(SYNC)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // reference model state
  int  m_cnt, m_aper, m_adt, s_per, s_dt;
  int  m_aduty[C];
  int  s_duty[C];
  bit  pend, running, m_sync;
  bit  rawq[C], level[C], was_off[C];
  int  age[C], dedge[C];
  logic [C-1:0] exp_h, exp_l;

  function automatic void m_reset();
    m_cnt = 0; m_aper = 0; m_adt = 0; s_per = 0; s_dt = 0;
    pend = 0; running = 0; m_sync = 0;
    exp_h = '0; exp_l = '0;
    for (int i = 0; i < C; i++) begin
      m_aduty[i] = 0; s_duty[i] = 0;
      rawq[i] = 0; level[i] = 0; was_off[i] = 1; age[i] = 0; dedge[i] = 0;
    end
  endfunction

  function automatic void m_clock();
    int  oc;
    int  odt;
    int  oduty[C];
    bit  orun, app, r;
    oc = m_cnt; odt = m_adt; oduty = m_aduty; orun = running;
    app = CE && (m_cnt == m_aper) && pend;
    for (int i = 0; i < C; i++) begin
      r = (oc < oduty[i]);
      if (!(EN && orun)) begin
        exp_h[i] = 0; exp_l[i] = 0; was_off[i] = 1;
        if (CE) rawq[i] = r;
      end else if (CE) begin
        if (was_off[i] || r != rawq[i]) begin
          age[i] = 0; dedge[i] = odt; level[i] = r;
        end else if (age[i] < 1000) begin
          age[i]++;
        end
        rawq[i] = r; was_off[i] = 0;
        exp_h[i] = level[i] && (age[i] >= dedge[i]);
        exp_l[i] = !level[i] && (age[i] >= dedge[i]);
      end
    end
    if (CE) begin
      m_sync = (oc == 0);
      m_cnt = (oc == m_aper) ? 0 : oc + 1;
    end else begin
      m_sync = 0;
    end
    if (app) begin
      m_aper = s_per; m_adt = s_dt; m_aduty = s_duty; running = 1;
    end
    if (LOAD) begin
      s_per = int'(PERIOD); s_dt = int'(DEADTIME);
      for (int i = 0; i < C; i++) s_duty[i] = int'(DUTY[i*W +: W]);
      pend = 1;
    end else if (app) begin
      pend = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    m_clock();
    @(posedge CLK);
    #1;
    chk("pwm_h", 32'(PWM_H), 32'(exp_h));
    chk("pwm_l", 32'(PWM_L), 32'(exp_l));
    chk("sync", 32'(SYNC), 32'(m_sync));
    chk("overlap", 32'(PWM_H & PWM_L), 32'd0);
  endtask

  task automatic load(input int per, input int d0, input int d1, input int d2, input int dt);
    PERIOD = W'(per);
    DUTY = {W'(d2), W'(d1), W'(d0)};
    DEADTIME = D'(dt);
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  task automatic window(input string tag, input int eh, input int el, input int es);
    int hc, lc, sc;
    hc = 0; lc = 0; sc = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      hc += int'(PWM_H[0]); lc += int'(PWM_L[0]); sc += int'(SYNC);
    end
    chk({tag, "_hcnt"}, 32'(hc), 32'(eh));
    chk({tag, "_lcnt"}, 32'(lc), 32'(el));
    chk({tag, "_synccnt"}, 32'(sc), 32'(es));
  endtask

  task automatic wait_cnt(input int v);
    for (int k = 0; k < 40 && m_cnt != v; k++) step();
    chk("wait_cnt_timeout", 32'(m_cnt), 32'(v));
  endtask

  task automatic async_reset();
    #2 RST = 1'b1;
    #1;
    m_reset();
    chk("async_rst_h", 32'(PWM_H), 32'd0);
    chk("async_rst_l", 32'(PWM_L), 32'd0);
    chk("async_rst_sync", 32'(SYNC), 32'd0);
    @(posedge CLK);
    #1;
    chk("rst_hold_h", 32'(PWM_H), 32'd0);
    RST = 1'b0;
  endtask

  initial begin
    m_reset();
    #1;
    @(posedge CLK);
    #1;
    chk("reset_h", 32'(PWM_H), 32'd0);
    chk("reset_l", 32'(PWM_L), 32'd0);
    chk("reset_sync", 32'(SYNC), 32'd0);
    RST = 1'b0; CE = 1'b1; EN = 1'b1;
    repeat (5) step();

    // basic period, no dead time
    load(9, 4, 2, 7, 0);
    repeat (25) step();
    window("dt0", 4, 6, 1);

    // dead time of two
    load(9, 4, 2, 7, 2);
    repeat (25) step();
    window("dt2", 2, 4, 1);

    // 0 % then 100 %
    load(9, 0, 2, 7, 2);
    repeat (25) step();
    window("duty0", 0, 10, 1);
    load(9, 10, 2, 7, 2);
    repeat (25) step();
    window("duty100", 10, 0, 1);

    // mid-period reloads, last one wins at the wrap
    load(9, 4, 2, 7, 0);
    repeat (25) step();
    wait_cnt(5);
    load(9, 7, 2, 7, 0);
    wait_cnt(7);
    load(9, 6, 2, 7, 0);
    wait_cnt(0);
    repeat (12) step();
    window("reload", 6, 4, 1);

    // clock-enable gap with a LOAD captured while stalled
    wait_cnt(2);
    CE = 1'b0;
    step();
    load(9, 3, 2, 7, 0);
    step();
    CE = 1'b1;
    repeat (25) step();
    window("ce_gap", 3, 7, 1);

    // async reset with the high side on
    load(9, 8, 2, 7, 2);
    repeat (25) step();
    wait_cnt(6);
    chk("pre_reset_h0", 32'(PWM_H[0]), 32'd1);
    async_reset();
    repeat (10) step();
    load(9, 4, 2, 7, 2);
    repeat (25) step();

    // output enable drop and restore
    EN = 1'b0;
    repeat (3) step();
    EN = 1'b1;
    repeat (15) step();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      CE = ($urandom_range(0, 99) < 85);
      EN = ($urandom_range(0, 99) < 95);
      if ($urandom_range(0, 99) < 5)
        load($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14),
             $urandom_range(0, 14), $urandom_range(0, 5));
      else
        step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
